// File: rtl/axi_native_arbiter_pkg.sv
// rtl/axi_native_arbiter_pkg.sv - shared types and encodings for the AXI-to-native arbiter
package axi_native_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_BURST = 2'd1,
        ST_WR_RESP  = 2'd2,
        ST_RD_BURST = 2'd3
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int DATA_W = 256;
    localparam int STRB_W = 32;

endpackage

// File: rtl/axi_native_arbiter_beat_counter.sv
// rtl/axi_native_arbiter_beat_counter.sv - native_beat_counter: command and data beat counts for one burst
module native_beat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [7:0] len,
    input  logic       cmd_fire,
    input  logic       beat_fire,
    output logic       cmd_done,
    output logic       cmd_fin,
    output logic       beat_done,
    output logic       beat_fin,
    output logic       beat_last
);

    logic [8:0] cmd_count;
    logic [8:0] beat_count;
    logic [8:0] total;

    // Nine bits so a 256-beat burst (len=255) reaches its total without wrapping.
    assign total     = {1'b0, len} + 9'd1;
    assign cmd_done  = (cmd_count == total);
    assign beat_done = (beat_count == total);
    assign beat_last = (beat_count == {1'b0, len});

    // "fin" also covers the final handshake happening this very cycle.
    assign cmd_fin  = cmd_done  | (cmd_fire  & ((cmd_count  + 9'd1) == total));
    assign beat_fin = beat_done | (beat_fire & ((beat_count + 9'd1) == total));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cmd_count  <= 9'd0;
            beat_count <= 9'd0;
        end else begin
            if (cmd_fire && !cmd_done) begin
                cmd_count <= cmd_count + 9'd1;
            end
            if (beat_fire && !beat_done) begin
                beat_count <= beat_count + 9'd1;
            end
        end
    end

endmodule

// File: rtl/axi_native_arbiter.sv
// rtl/axi_native_arbiter.sv - arbitrates AXI write/read bursts onto a single native command port
module axi_native_arbiter
    import axi_native_arbiter_pkg::*;
#(
    parameter int NATIVE_AW = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 aw_valid,
    output logic                 aw_ready,
    input  logic [31:0]          aw_addr,
    input  logic [1:0]           aw_burst,
    input  logic [7:0]           aw_len,
    input  logic                 aw_id,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [DATA_W-1:0]    w_data,
    input  logic [STRB_W-1:0]    w_strb,
    input  logic                 w_last,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [1:0]           b_resp,
    output logic                 b_id,
    input  logic                 ar_valid,
    output logic                 ar_ready,
    input  logic [31:0]          ar_addr,
    input  logic [1:0]           ar_burst,
    input  logic [7:0]           ar_len,
    input  logic                 ar_id,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic [DATA_W-1:0]    r_data,
    output logic [1:0]           r_resp,
    output logic                 r_last,
    output logic                 r_id,
    output logic                 native_cmd_valid,
    input  logic                 native_cmd_ready,
    output logic                 native_cmd_payload_we,
    output logic                 native_cmd_payload_mw,
    output logic [NATIVE_AW-1:0] native_cmd_payload_addr,
    output logic                 wdata_valid,
    input  logic                 wdata_ready,
    output logic [DATA_W-1:0]    wdata_payload_data,
    output logic [STRB_W-1:0]    wdata_payload_we,
    input  logic                 rdata_valid,
    output logic                 rdata_ready,
    input  logic [DATA_W-1:0]    rdata_payload_data
);

    state_t               state;
    logic                 last_grant_read;
    logic [7:0]           len_q;
    logic [1:0]           burst_q;
    logic                 id_q;
    logic [NATIVE_AW-1:0] cmd_addr;

    logic grant_write, grant_read;
    logic in_wr, in_rd, wr_fwd;
    logic cmd_fire, wbeat_fire, r_fire;
    logic wr_cmd_done, wr_cmd_fin, wr_beat_done, wr_beat_fin, wr_beat_last;
    logic rd_cmd_done, rd_cmd_fin, rd_beat_done, rd_beat_fin, rd_beat_last;

    // On a tie the side that did not win last time gets the port.
    assign grant_write = !rst && (state == ST_IDLE) && aw_valid && (!ar_valid || last_grant_read);
    assign grant_read  = !rst && (state == ST_IDLE) && ar_valid && (!aw_valid || !last_grant_read);
    assign aw_ready    = grant_write;
    assign ar_ready    = grant_read;

    assign in_wr = (state == ST_WR_BURST);
    assign in_rd = (state == ST_RD_BURST);

    assign native_cmd_valid        = (in_wr && !wr_cmd_done) || (in_rd && !rd_cmd_done);
    assign native_cmd_payload_we   = in_wr;
    assign native_cmd_payload_mw   = 1'b0;
    assign native_cmd_payload_addr = (in_wr || in_rd) ? cmd_addr : '0;
    assign cmd_fire                = native_cmd_valid && native_cmd_ready;

    // Write data passes straight through until the burst's beat quota is met.
    assign wr_fwd             = in_wr && !wr_beat_done;
    assign wdata_valid        = wr_fwd && w_valid;
    assign w_ready            = wr_fwd && wdata_ready;
    assign wdata_payload_data = wr_fwd ? w_data : '0;
    assign wdata_payload_we   = wr_fwd ? w_strb : '0;
    assign wbeat_fire         = wdata_valid && wdata_ready;

    assign b_valid = (state == ST_WR_RESP);
    assign b_resp  = RESP_OKAY;
    assign b_id    = b_valid ? id_q : 1'b0;

    assign rdata_ready = in_rd && r_ready;
    assign r_valid     = in_rd && rdata_valid;
    assign r_data      = in_rd ? rdata_payload_data : '0;
    assign r_resp      = RESP_OKAY;
    assign r_last      = in_rd && rd_beat_last;
    assign r_id        = in_rd ? id_q : 1'b0;
    assign r_fire      = r_valid && r_ready;

    native_beat_counter u_wr_count (
        .clk       (clk),
        .rst       (rst),
        .clear     (grant_write),
        .len       (len_q),
        .cmd_fire  (cmd_fire && in_wr),
        .beat_fire (wbeat_fire),
        .cmd_done  (wr_cmd_done),
        .cmd_fin   (wr_cmd_fin),
        .beat_done (wr_beat_done),
        .beat_fin  (wr_beat_fin),
        .beat_last (wr_beat_last)
    );

    native_beat_counter u_rd_count (
        .clk       (clk),
        .rst       (rst),
        .clear     (grant_read),
        .len       (len_q),
        .cmd_fire  (cmd_fire && in_rd),
        .beat_fire (r_fire),
        .cmd_done  (rd_cmd_done),
        .cmd_fin   (rd_cmd_fin),
        .beat_done (rd_beat_done),
        .beat_fin  (rd_beat_fin),
        .beat_last (rd_beat_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            last_grant_read <= 1'b1;
            len_q           <= 8'd0;
            burst_q         <= BURST_FIXED;
            id_q            <= 1'b0;
            cmd_addr        <= '0;
        end else begin
            // Any non-FIXED encoding (INCR, WRAP, reserved) walks linearly.
            if (cmd_fire && (burst_q != BURST_FIXED)) begin
                cmd_addr <= cmd_addr + NATIVE_AW'(1);
            end
            unique case (state)
                ST_IDLE: begin
                    if (grant_write) begin
                        len_q           <= aw_len;
                        burst_q         <= aw_burst;
                        id_q            <= aw_id;
                        cmd_addr        <= aw_addr[NATIVE_AW+4:5];
                        last_grant_read <= 1'b0;
                        state           <= ST_WR_BURST;
                    end else if (grant_read) begin
                        len_q           <= ar_len;
                        burst_q         <= ar_burst;
                        id_q            <= ar_id;
                        cmd_addr        <= ar_addr[NATIVE_AW+4:5];
                        last_grant_read <= 1'b1;
                        state           <= ST_RD_BURST;
                    end
                end
                ST_WR_BURST: begin
                    if (wr_cmd_fin && wr_beat_fin) begin
                        state <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (b_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RD_BURST: begin
                    if (r_fire && rd_beat_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic unused_sink;
    assign unused_sink = ^{w_last, aw_addr, ar_addr, wr_beat_last, rd_cmd_fin,
                           rd_beat_done, rd_beat_fin, BURST_INCR, BURST_WRAP};

endmodule

// File: doc/axi_native_arbiter.md
AXI_NATIVE_ARBITER -- requirements
Module: axi_native_arbiter

Interface
REQ-001 Parameter: NATIVE_AW, default 26, native command address width (32-byte word units).
REQ-002 clk  input  1  sole clock; all logic on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 aw_valid/aw_ready  in/out  1/1; aw_addr in 32; aw_burst in 2; aw_len in 8; aw_id in 1: AXI write address.
REQ-005 w_valid/w_ready  in/out  1/1; w_data in 256; w_strb in 32; w_last in 1: AXI write data.
REQ-006 b_valid/b_ready  out/in  1/1; b_resp out 2; b_id out 1: AXI write response.
REQ-007 ar_valid/ar_ready  in/out  1/1; ar_addr in 32; ar_burst in 2; ar_len in 8; ar_id in 1: AXI read address.
REQ-008 r_valid/r_ready  out/in  1/1; r_data out 256; r_resp out 2; r_last out 1; r_id out 1: AXI read data.
REQ-009 native_cmd_valid/native_cmd_ready  out/in  1/1; native_cmd_payload_we out 1; native_cmd_payload_mw out 1; native_cmd_payload_addr out NATIVE_AW: native command.
REQ-010 wdata_valid/wdata_ready  out/in  1/1; wdata_payload_data out 256; wdata_payload_we out 32: native write data.
REQ-011 rdata_valid/rdata_ready  in/out  1/1; rdata_payload_data in 256: native read data.

Function
REQ-012 FSM states: IDLE, WR_BURST, WR_RESP, RD_BURST; one burst owns the native port at a time.
REQ-013 IDLE: aw_valid only -> grant write; ar_valid only -> grant read; both -> grant side opposite to last_grant (reset value: read, so first tie grants write).
REQ-014 Grant pulses aw_ready or ar_ready for exactly one cycle in IDLE, latches addr/burst/len/id, updates last_grant, enters WR_BURST/RD_BURST next cycle.
REQ-015 Native address = axi_addr[NATIVE_AW+4:5]; INCR (01) and WRAP (10) increment by 1 per beat modulo 2^NATIVE_AW; FIXED (00) holds; 11 treated as INCR.
REQ-016 WR_BURST: issue len+1 commands (we=1, mw=0); command count advances on native_cmd_valid&native_cmd_ready; native_cmd_valid low once all issued.
REQ-017 WR_BURST data: wdata_valid=w_valid, w_ready=wdata_ready, data/strb->data/we, combinationally, while beats accepted < len+1; else w_ready=0.
REQ-018 WR_BURST exits to WR_RESP when all commands and len+1 data beats accepted (same-cycle completion allowed); w_last is not checked.
REQ-019 WR_RESP: b_valid=1, b_resp=00, b_id=latched aw_id; on b_ready -> IDLE.
REQ-020 RD_BURST: issue len+1 commands (we=0, mw=0) as in REQ-016; rdata_ready=r_ready; r_valid=rdata_valid; r_data=rdata_payload_data; r_resp=00; r_id=latched ar_id.
REQ-021 r_last=1 on beat index len; the handshake of that beat -> IDLE; rdata_valid outside RD_BURST is not forwarded (rdata_ready=0).
REQ-022 len=0 bursts: one command, one beat; len=255: 256 beats, 9-bit counters, no overflow.
REQ-023 aw_ready, ar_ready, native_cmd_valid, wdata_valid, b_valid, r_valid all 0 outside their owning state.

Reset
REQ-024 rst: FSM->IDLE, counters 0, last_grant=read, all valid/ready outputs 0, payload outputs 0, next cycle after deassertion.
REQ-025 rst mid-burst aborts silently; no b or r response issued for the aborted burst.

Structure
REQ-026 Shared package holds the state enum, AXI burst/resp encodings, and data (256) / strobe (32) widths.
REQ-027 One sub-module, native_beat_counter: counts command issues and data beats against len and flags done; instantiated once per burst direction.

Verification
REQ-028 Write aw_addr=0x0000_0040, len=3, INCR -> 4 commands, addr 2,3,4,5, we=1; 4 wdata beats; then b_valid with resp 00, id echoed.
REQ-029 Read ar_addr=0x100, len=0, FIXED -> 1 command, addr 8, we=0; 1 r beat with r_last=1, then IDLE.
REQ-030 aw_valid and ar_valid both asserted from reset -> write granted first, read granted next; then repeated ties alternate grants.
REQ-031 Write at native addr 0x3FF_FFFE, len=3, INCR -> addresses 0x3FF_FFFE, 0x3FF_FFFF, 0x000_0000, 0x000_0001.
REQ-032 Backpressure: random native_cmd_ready/wdata_ready/r_ready stalls -> no lost or duplicated beat; read data order preserved; r_last exactly once.
REQ-033 rst asserted during beat 2 of a len=7 read -> next cycle all outputs 0, IDLE; new write accepted afterward.
